// File: rtl/misaligned_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : misaligned_access_sequencer
// Description : Load/store sequencer between the CPU memory stage and an
//               aligned-only data memory. Aligned and byte accesses pass
//               through in one memory cycle. Misaligned halfword/word loads
//               are served by two aligned word reads that are merged and
//               extended. Misaligned halfword/word stores are broken into
//               per-byte stores.
// Ports       : clk, rst_n                 clock / async active-low reset
//               i_req_*  / o_req_ready     request handshake from the CPU
//               o_resp_*                   one-cycle completion pulse
//               o_mem_*  / i_mem_rd_val    aligned data-memory port
// Revision    : 1.0 - initial release
// ============================================================================
module misaligned_access_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [2:0]  i_req_size,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic [31:0] o_mem_access_addr,
    output logic [31:0] o_mem_wr_val,
    output logic        o_mem_write_en,
    output logic        o_mem_read_en,
    output logic [2:0]  o_mem_data_size,
    input  logic [31:0] i_mem_rd_val
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SINGLE  = 3'd1;
    localparam logic [2:0] S_LD_LO   = 3'd2;
    localparam logic [2:0] S_LD_HI   = 3'd3;
    localparam logic [2:0] S_ST_BYTE = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    localparam logic [2:0] c_SIZE_B = 3'b000;
    localparam logic [2:0] c_SIZE_W = 3'b010;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;

    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [31:0] r_lo;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [1:0]  r_cnt;

    logic        w_accept;
    logic        w_req_err;
    logic        w_req_single;
    logic        w_last_byte;
    logic [31:0] w_word_base;
    logic [31:0] w_shifted;
    logic [31:0] w_merged;
    logic [7:0]  w_st_byte;

    assign w_accept = i_req_valid && o_req_ready;

    // Sizes 011, 110 and 111 have no RV32 meaning.
    assign w_req_err = (i_req_size == 3'b011) || (i_req_size == 3'b110) ||
                       (i_req_size == 3'b111);

    // size[1:0] selects width (00 byte, 01 half, 10 word); size[2] = unsigned.
    assign w_req_single = (i_req_size[1:0] == 2'b00) ||
                          ((i_req_size[1:0] == 2'b01) && !i_req_addr[0]) ||
                          ((i_req_size[1:0] == 2'b10) && (i_req_addr[1:0] == 2'b00));

    // Word stores take four byte cycles, halfword stores two.
    assign w_last_byte = (r_cnt == (r_size[1] ? 2'd3 : 2'd1));

    assign w_word_base = {r_addr[31:2], 2'b00};

    // The two aligned words form a 64-bit window; shift by the byte offset.
    assign w_shifted = 32'({i_mem_rd_val, r_lo} >> {r_addr[1:0], 3'b000});
    assign w_merged  = (r_size[1:0] == 2'b01)
                     ? {{16{w_shifted[15] & ~r_size[2]}}, w_shifted[15:0]}
                     : w_shifted;

    always_comb begin
        w_st_byte = r_wdata[7:0];
        case (r_cnt)
            2'd1:    w_st_byte = r_wdata[15:8];
            2'd2:    w_st_byte = r_wdata[23:16];
            2'd3:    w_st_byte = r_wdata[31:24];
            default: w_st_byte = r_wdata[7:0];
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_next_state = S_RESP;
                    end else if (w_req_single) begin
                        w_next_state = S_SINGLE;
                    end else if (i_req_write) begin
                        w_next_state = S_ST_BYTE;
                    end else begin
                        w_next_state = S_LD_LO;
                    end
                end
            end
            S_SINGLE:  w_next_state = S_RESP;
            S_LD_LO:   w_next_state = S_LD_HI;
            S_LD_HI:   w_next_state = S_RESP;
            S_ST_BYTE: w_next_state = w_last_byte ? S_RESP : S_ST_BYTE;
            S_RESP:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Request capture and load-data datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_size  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_lo    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= i_req_addr;
                        r_size  <= i_req_size;
                        r_write <= i_req_write;
                        r_wdata <= i_req_wdata;
                        r_err   <= w_req_err;
                        r_rdata <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_SINGLE: begin
                    // The memory already extends single-cycle load data.
                    if (!r_write) begin
                        r_rdata <= i_mem_rd_val;
                    end
                end
                S_LD_LO: r_lo    <= i_mem_rd_val;
                S_LD_HI: r_rdata <= w_merged;
                S_ST_BYTE: r_cnt <= w_last_byte ? 2'd0 : r_cnt + 2'd1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output logic; every memory field stays zero while its enable is low.
    // ------------------------------------------------------------------------
    always_comb begin
        o_req_ready       = (r_state == S_IDLE) && rst_n;
        o_resp_valid      = 1'b0;
        o_resp_rdata      = '0;
        o_resp_err        = 1'b0;
        o_mem_access_addr = '0;
        o_mem_wr_val      = '0;
        o_mem_write_en    = 1'b0;
        o_mem_read_en     = 1'b0;
        o_mem_data_size   = '0;
        case (r_state)
            S_SINGLE: begin
                o_mem_access_addr = r_addr;
                o_mem_data_size   = r_size;
                if (r_write) begin
                    o_mem_write_en = 1'b1;
                    o_mem_wr_val   = r_wdata;
                end else begin
                    o_mem_read_en  = 1'b1;
                end
            end
            S_LD_LO: begin
                o_mem_access_addr = w_word_base;
                o_mem_data_size   = c_SIZE_W;
                o_mem_read_en     = 1'b1;
            end
            S_LD_HI: begin
                o_mem_access_addr = w_word_base + 32'd4;
                o_mem_data_size   = c_SIZE_W;
                o_mem_read_en     = 1'b1;
            end
            S_ST_BYTE: begin
                o_mem_access_addr = r_addr + {30'd0, r_cnt};
                o_mem_data_size   = c_SIZE_B;
                o_mem_wr_val      = {24'd0, w_st_byte};
                o_mem_write_en    = 1'b1;
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                o_resp_rdata = r_rdata;
                o_resp_err   = r_err;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_misaligned_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_misaligned_access_sequencer
// Description : Directed self-checking bench for misaligned_access_sequencer
//               with a small aligned data-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_misaligned_access_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_access_addr;
    logic [31:0] mem_wr_val;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [2:0]  mem_data_size;
    logic [31:0] mem_rd_val;

    misaligned_access_sequencer u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_req_valid       (req_valid),
        .o_req_ready       (req_ready),
        .i_req_write       (req_write),
        .i_req_addr        (req_addr),
        .i_req_size        (req_size),
        .i_req_wdata       (req_wdata),
        .o_resp_valid      (resp_valid),
        .o_resp_rdata      (resp_rdata),
        .o_resp_err        (resp_err),
        .o_mem_access_addr (mem_access_addr),
        .o_mem_wr_val      (mem_wr_val),
        .o_mem_write_en    (mem_write_en),
        .o_mem_read_en     (mem_read_en),
        .o_mem_data_size   (mem_data_size),
        .i_mem_rd_val      (mem_rd_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // ---------------- data memory model (aligned accesses only) ----------------
    logic [31:0] d_mem [0:15];
    logic [1:0]  mem_cmd = 2'd0;   // 1 = clear, 2 = preload
    logic [31:0] mr_word;
    logic [31:0] mr_sh;

    always_comb begin
        mr_word    = d_mem[mem_access_addr[5:2]];
        mr_sh      = mr_word >> {mem_access_addr[1:0], 3'b000};
        mem_rd_val = mr_word;
        case (mem_data_size)
            3'b000:  mem_rd_val = {{24{mr_sh[7]}}, mr_sh[7:0]};
            3'b100:  mem_rd_val = {24'd0, mr_sh[7:0]};
            3'b001:  mem_rd_val = {{16{mr_sh[15]}}, mr_sh[15:0]};
            3'b101:  mem_rd_val = {16'd0, mr_sh[15:0]};
            default: mem_rd_val = mr_word;
        endcase
    end

    always @(posedge clk) begin
        if (mem_cmd != 2'd0) begin
            for (int i = 0; i < 16; i++) d_mem[i] <= 32'd0;
            if (mem_cmd == 2'd2) begin
                d_mem[0] <= 32'hc4c3c2c1;
                d_mem[1] <= 32'hd4d3d2d1;
                d_mem[2] <= 32'he4e3e2e1;
            end
        end else if (mem_write_en) begin
            case (mem_data_size)
                3'b000:  d_mem[mem_access_addr[5:2]][{mem_access_addr[1:0], 3'b000} +: 8] <= mem_wr_val[7:0];
                3'b001:  d_mem[mem_access_addr[5:2]][{mem_access_addr[1], 4'b0000} +: 16] <= mem_wr_val[15:0];
                default: d_mem[mem_access_addr[5:2]] <= mem_wr_val;
            endcase
        end
    end

    // ---------------- bus monitor ----------------
    logic [31:0] rd_log [0:255];
    logic [2:0]  rd_sz_log [0:255];
    logic [31:0] wr_log [0:255];
    int rd_total = 0, wr_total = 0, acc_total = 0, resp_total = 0, both_total = 0;

    always @(posedge clk) begin
        if (mem_read_en) begin
            rd_log[rd_total % 256]    <= mem_access_addr;
            rd_sz_log[rd_total % 256] <= mem_data_size;
            rd_total <= rd_total + 1;
        end
        if (mem_write_en) begin
            wr_log[wr_total % 256] <= mem_access_addr;
            wr_total <= wr_total + 1;
        end
        if (mem_read_en && mem_write_en) both_total <= both_total + 1;
        if (req_valid && req_ready) acc_total <= acc_total + 1;
        if (resp_valid) resp_total <= resp_total + 1;
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] got_rd;
    logic        got_err;
    int          got_lat;
    int          rd0, wr0;

    task automatic mem_set(input logic [1:0] m);
        @(negedge clk) mem_cmd = m;
        @(negedge clk) mem_cmd = 2'd0;
    endtask

    // Issues one request and measures accept-edge-to-resp_valid latency.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [2:0] s,
                          input logic [31:0] wd);
        @(negedge clk);
        rd0 = rd_total; wr0 = wr_total;
        req_valid = 1'b1; req_write = w; req_addr = a; req_size = s; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        got_lat = 1;
        while (!resp_valid && got_lat < 20) begin
            @(negedge clk);
            got_lat++;
        end
        got_rd  = resp_rdata;
        got_err = resp_err;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_size = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        vecs++; if ({resp_valid, mem_read_en, mem_write_en} !== 3'b000) begin errs++; $display("FAIL reset_ctrl: got %b want 000", {resp_valid, mem_read_en, mem_write_en}); end
        vecs++; if (mem_access_addr !== 32'd0) begin errs++; $display("FAIL reset_addr: got %h want 0", mem_access_addr); end
        rst_n = 1'b1;
        #1;
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_aligned_load();
        mem_set(2'd2);
        do_req(1'b0, 32'h4, 3'b010, 32'd0);
        vecs++; if (got_rd !== 32'hd4d3d2d1) begin errs++; $display("FAIL lw4_data: got %h want d4d3d2d1", got_rd); end
        vecs++; if (got_err !== 1'b0) begin errs++; $display("FAIL lw4_err: got %b want 0", got_err); end
        vecs++; if (got_lat != 2) begin errs++; $display("FAIL lw4_lat: got %0d want 2", got_lat); end
        vecs++; if (rd_total - rd0 != 1) begin errs++; $display("FAIL lw4_nrd: got %0d want 1", rd_total - rd0); end
        vecs++; if ({rd_log[rd0 % 256], rd_sz_log[rd0 % 256]} !== {32'h4, 3'b010}) begin errs++; $display("FAIL lw4_bus: got %h/%b want 4/010", rd_log[rd0 % 256], rd_sz_log[rd0 % 256]); end
    endtask

    task automatic test_misaligned_load();
        do_req(1'b0, 32'h5, 3'b010, 32'd0);
        vecs++; if (got_rd !== 32'he1d4d3d2) begin errs++; $display("FAIL lw5_data: got %h want e1d4d3d2", got_rd); end
        vecs++; if (got_lat != 3) begin errs++; $display("FAIL lw5_lat: got %0d want 3", got_lat); end
        vecs++; if ({rd_log[rd0 % 256], rd_log[(rd0 + 1) % 256]} !== {32'h4, 32'h8}) begin errs++; $display("FAIL lw5_addrs: got %h,%h want 4,8", rd_log[rd0 % 256], rd_log[(rd0 + 1) % 256]); end
        do_req(1'b0, 32'h7, 3'b001, 32'd0);
        vecs++; if (got_rd !== 32'hffffe1d4) begin errs++; $display("FAIL lh7_data: got %h want ffffe1d4", got_rd); end
        do_req(1'b0, 32'h7, 3'b101, 32'd0);
        vecs++; if (got_rd !== 32'h0000e1d4) begin errs++; $display("FAIL lhu7_data: got %h want 0000e1d4", got_rd); end
        do_req(1'b0, 32'h6, 3'b010, 32'd0);
        vecs++; if (got_rd !== 32'he2e1d4d3) begin errs++; $display("FAIL lw6_data: got %h want e2e1d4d3", got_rd); end
    endtask

    task automatic test_misaligned_store();
        mem_set(2'd1);
        do_req(1'b1, 32'h6, 3'b010, 32'hf7f6f5f4);
        vecs++; if (got_lat != 5) begin errs++; $display("FAIL sw6_lat: got %0d want 5", got_lat); end
        vecs++; if (got_rd !== 32'd0) begin errs++; $display("FAIL sw6_rdata: got %h want 0", got_rd); end
        vecs++; if (wr_total - wr0 != 4) begin errs++; $display("FAIL sw6_nwr: got %0d want 4", wr_total - wr0); end
        for (int i = 0; i < 4; i++) begin
            vecs++; if (wr_log[(wr0 + i) % 256] !== 32'h6 + i) begin errs++; $display("FAIL sw6_addr%0d: got %h want %h", i, wr_log[(wr0 + i) % 256], 32'h6 + i); end
        end
        vecs++; if ({d_mem[1], d_mem[2]} !== {32'hf5f40000, 32'h0000f7f6}) begin errs++; $display("FAIL sw6_mem: got %h %h want f5f40000 0000f7f6", d_mem[1], d_mem[2]); end
        mem_set(2'd1);
        do_req(1'b1, 32'h3, 3'b001, 32'h00001234);
        vecs++; if (got_lat != 3) begin errs++; $display("FAIL sh3_lat: got %0d want 3", got_lat); end
        vecs++; if ({d_mem[0], d_mem[1]} !== {32'h34000000, 32'h00000012}) begin errs++; $display("FAIL sh3_mem: got %h %h want 34000000 00000012", d_mem[0], d_mem[1]); end
    endtask

    task automatic test_passthrough();
        mem_set(2'd2);
        do_req(1'b0, 32'h7, 3'b000, 32'd0);
        vecs++; if (got_rd !== 32'hffffffd4) begin errs++; $display("FAIL lb7_data: got %h want ffffffd4", got_rd); end
        vecs++; if (got_lat != 2) begin errs++; $display("FAIL lb7_lat: got %0d want 2", got_lat); end
        mem_set(2'd1);
        do_req(1'b1, 32'h6, 3'b001, 32'hf7f6f5f4);
        vecs++; if (wr_total - wr0 != 1) begin errs++; $display("FAIL sh6_nwr: got %0d want 1", wr_total - wr0); end
        vecs++; if (d_mem[1] !== 32'hf5f40000) begin errs++; $display("FAIL sh6_mem: got %h want f5f40000", d_mem[1]); end
        vecs++; if (got_lat != 2) begin errs++; $display("FAIL sh6_lat: got %0d want 2", got_lat); end
    endtask

    task automatic test_illegal();
        do_req(1'b0, 32'h4, 3'b011, 32'd0);
        vecs++; if (got_lat != 1) begin errs++; $display("FAIL err_lat: got %0d want 1", got_lat); end
        vecs++; if ({got_err, got_rd} !== {1'b1, 32'd0}) begin errs++; $display("FAIL err_resp: got %b/%h want 1/0", got_err, got_rd); end
        vecs++; if ((rd_total - rd0) + (wr_total - wr0) != 0) begin errs++; $display("FAIL err_noaccess: got %0d want 0", (rd_total - rd0) + (wr_total - wr0)); end
    endtask

    task automatic test_reset_mid_op();
        int r0;
        mem_set(2'd1);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h6; req_size = 3'b010; req_wdata = 32'hf7f6f5f4;
        @(posedge clk);
        @(negedge clk) req_valid = 1'b0;    // first byte cycle
        @(negedge clk);                      // second byte cycle
        r0 = resp_total;
        rst_n = 1'b0;
        #1;
        vecs++; if ({mem_write_en, mem_read_en, req_ready} !== 3'b000) begin errs++; $display("FAIL rst_mid_en: got %b want 000", {mem_write_en, mem_read_en, req_ready}); end
        vecs++; if (mem_access_addr !== 32'd0) begin errs++; $display("FAIL rst_mid_addr: got %h want 0", mem_access_addr); end
        repeat (3) @(negedge clk);
        vecs++; if (resp_total != r0) begin errs++; $display("FAIL rst_mid_noresp: got %0d want %0d", resp_total, r0); end
        vecs++; if (d_mem[1] !== 32'h00f40000) begin errs++; $display("FAIL rst_mid_mem: got %h want 00f40000", d_mem[1]); end
        rst_n = 1'b1;
        #1;
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
        mem_set(2'd2);
        do_req(1'b0, 32'h4, 3'b010, 32'd0);
        vecs++; if ({got_rd, got_lat[3:0]} !== {32'hd4d3d2d1, 4'd2}) begin errs++; $display("FAIL rst_mid_lw: got %h lat %0d want d4d3d2d1 lat 2", got_rd, got_lat); end
    endtask

    task automatic test_back_to_back();
        int a0, s0;
        @(negedge clk);
        a0 = acc_total; s0 = resp_total;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4; req_size = 3'b010; req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL b2b_ready_single: got %b want 0", req_ready); end
        @(negedge clk);
        vecs++; if ({req_ready, resp_valid} !== 2'b01) begin errs++; $display("FAIL b2b_ready_resp: got %b want 01", {req_ready, resp_valid}); end
        @(negedge clk);
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready_idle: got %b want 1", req_ready); end
        repeat (3) @(posedge clk);
        @(negedge clk) req_valid = 1'b0;
        vecs++; if (acc_total - a0 != 2) begin errs++; $display("FAIL b2b_accepts: got %0d want 2", acc_total - a0); end
        vecs++; if (resp_total - s0 != 2) begin errs++; $display("FAIL b2b_resps: got %0d want 2", resp_total - s0); end
        vecs++; if (both_total != 0) begin errs++; $display("FAIL both_enables: got %0d want 0", both_total); end
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_misaligned_load();
        test_misaligned_store();
        test_passthrough();
        test_illegal();
        test_reset_mid_op();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/misaligned_access_sequencer.md
# misaligned_access_sequencer

Load/store sequencer between the CPU memory stage and `DataMemory`. It accepts one load or store request at a time. Aligned and byte accesses go to `DataMemory` unchanged in one memory cycle. Misaligned halfword and word accesses are split into a sequence of aligned memory operations, and load results are merged and extended. This is what gives the core correct RV32 misaligned-access semantics on top of a memory that only does aligned accesses.

## Interface
Parameters:
- none; addresses and data are fixed at 32 bits.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept; `(state==IDLE) && rst_n`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_size`  in  3  funct3 encoding: `000` b, `001` h, `010` w, `100` bu, `101` hu.
- `req_wdata`  in  32  store data, low bytes significant.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result, extended; 0 for stores and errors.
- `resp_err`  out  1  illegal `req_size`, valid with `resp_valid`.
- `mem_access_addr`  out  32  to `DataMemory`.
- `mem_wr_val`  out  32  to `DataMemory`.
- `mem_write_en`  out  1  to `DataMemory`.
- `mem_read_en`  out  1  to `DataMemory`.
- `mem_data_size`  out  3  to `DataMemory`.
- `mem_rd_val`  in  32  from `DataMemory`; combinational from address, sampled at the clock edge.

## Operation
- Accept when `req_valid && req_ready` at a rising edge. Addr, size, write and wdata are captured. `k = addr[1:0]`.
- Classification:
  - Size in {011, 110, 111}: ERR.
  - Byte access, halfword with `addr[0]==0`, or word with `k==0`: SINGLE.
  - Otherwise: misaligned.
- States: IDLE, SINGLE, LD_LO, LD_HI, ST_BYTE, RESP.
  - IDLE: accept goes to SINGLE, LD_LO, ST_BYTE, or RESP (ERR).
  - SINGLE: drive the captured addr, size and wdata with `mem_read_en` or `mem_write_en` set. Load data is captured at the edge. Next state RESP.
  - LD_LO: read `{addr[31:2],2'b00}` with size `010` and capture `lo`. Next state LD_HI.
  - LD_HI: read `{addr[31:2],2'b00}+4` with size `010` (wraps modulo 2^32) and capture `hi`. Next state RESP.
  - Misaligned load result: `{hi,lo} >> (8*k)`, truncated to 16 or 32 bits. Sign-extend for `001`; zero-extend for `101`.
  - ST_BYTE: N byte stores (N=2 for h, 4 for w). Store i writes address `addr+i` (mod 2^32) with size `000` and `mem_wr_val = {24'b0, wdata[8i+7:8i]}`. There is one store per cycle, counted by a 2-bit counter. After store N-1, go to RESP.
  - RESP: `resp_valid=1` with data/err. Next state IDLE.
- Memory enables are asserted only in SINGLE, LD_LO, LD_HI and ST_BYTE, and never both at once.
- `mem_*` outputs are 0 whenever enables are low.
- `req_*` inputs are ignored outside IDLE.

## Timing
- Reset (async): state IDLE, counter 0, captured registers 0.
  - All outputs 0, including `req_ready`, while `rst_n` is low.
  - `req_ready` rises with reset release.
- Latency from the accept edge to `resp_valid` high:
  - SINGLE: 2 cycles.
  - Misaligned load: 3 cycles.
  - Misaligned sh: 3 cycles.
  - Misaligned sw: 5 cycles.
  - ERR: 1 cycle.
- Issue rate: next accept no earlier than the edge ending RESP, so back-to-back requests are spaced at latency + 1.
- Reset mid-operation: enables drop immediately and no response is issued. Bytes already written stay written; store atomicity is not guaranteed.
- Misaligned access crossing 0xFFFFFFFF wraps to 0x00000000.

## Test plan
Memory preload for loads: `d_mem[0..2] = c4c3c2c1, d4d3d2d1, e4e3e2e1`. Stores start from zeroed memory.

1. Aligned lw at 0x4 -> two cycles later `resp_rdata=d4d3d2d1`, `resp_err=0`. Exactly one `mem_read_en` cycle, with addr 0x4 and size 010.
2. Misaligned loads:
   - lw at 0x5 -> `e1d4d3d2` after 3 cycles; read addresses 0x4 then 0x8.
   - lh at 0x7 -> `ffffe1d4`.
   - lhu at 0x7 -> `0000e1d4`.
   - lw at 0x6 -> `e2e1d4d3`.
3. Misaligned stores:
   - sw at 0x6 with `f7f6f5f4` -> four sb cycles at 0x6..0x9, then `d_mem[1]=f5f40000`, `d_mem[2]=0000f7f6`; resp 5 cycles after accept.
   - sh at 0x3 with `00001234` -> `d_mem[0]=34000000`, `d_mem[1]=00000012`.
4. Byte and aligned-halfword passthrough:
   - lb at 0x7 -> `ffffffd4`.
   - sh at 0x6 with `f7f6f5f4` -> single write cycle, `d_mem[1]=f5f40000`.
5. Illegal size 011 -> `resp_valid` and `resp_err` one cycle after accept, `resp_rdata=0`, no memory enable ever asserted.
6. Reset and handshake:
   - Assert `rst_n=0` during the 2nd byte of a misaligned sw -> enables drop at once and no `resp_valid` is issued. After release, `req_ready=1` and a following lw at 0x4 completes normally.
   - `req_valid` held high during a busy period -> `req_ready` stays 0 and nothing is accepted until RESP ends.
